// File: rtl/regfile_sb_pkg.sv
// Shared datapath constants for the register file and its scoreboard.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_sb_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ASIZE_DEF = 4;
  localparam int NREG_DEF  = 16;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  // Busy count must hold the value NREG, hence one bit wider than an address.
  localparam int BCNT_W = ASIZE_DEF + 1;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue reserves a register, writeback releases it.
// Honours REGFILE_ZERO_REG_EN through regfile_sb_pkg::ZERO_REG_EN.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREG-1:0]  clr,
  input  logic             rsv_en,
  input  logic [ASIZE-1:0] rsv_addr,
  output logic             rsv_ok,
  output logic [NREG-1:0]  busy_eff,
  output logic [NREG-1:0]  busy_vec,
  output logic [ASIZE:0]   busy_cnt
);

  localparam int CW = ASIZE + 1;

  logic [NREG-1:0] r_busy_vec;
  logic [CW-1:0]   r_busy_cnt;
  logic [NREG-1:0] w_busy_eff;
  logic [NREG-1:0] w_busy_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_in_range;
  logic            w_sel_busy;
  logic            w_rsv_ok;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_busy_eff = r_busy_vec & ~clr;
    w_in_range = ({1'b0, rsv_addr} < CW'(NREG));
    w_sel_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rsv_addr == ASIZE'(i)) w_sel_busy = w_busy_eff[i];
    end
    w_rsv_ok = rsv_en & w_in_range & ~w_sel_busy
             & ~(ZERO_REG_EN && (rsv_addr == '0));

    // A new reservation wins over a same-cycle release of that register.
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_rsv_ok && (rsv_addr == ASIZE'(i))) w_busy_nxt[i] = 1'b1;
      else if (clr[i])                         w_busy_nxt[i] = 1'b0;
      else                                     w_busy_nxt[i] = r_busy_vec[i];
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_vec <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy_vec <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign rsv_ok   = w_rsv_ok;
  assign busy_eff = w_busy_eff;
  assign busy_vec = r_busy_vec;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read forwarding and a busy scoreboard.
// Build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*ASIZE-1:0] waddr,
  input  logic [NWR*DSIZE-1:0] wdata,
  input  logic [NRD*ASIZE-1:0] raddr,
  output logic [NRD*DSIZE-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 rsv_en,
  input  logic [ASIZE-1:0]     rsv_addr,
  output logic                 rsv_ok,
  output logic [NREG-1:0]      busy_vec,
  output logic [ASIZE:0]       busy_cnt
);

  localparam int CW = ASIZE + 1;

  logic [DSIZE-1:0] r_mem [NREG];

  logic [ASIZE-1:0] w_waddr [NWR];
  logic [DSIZE-1:0] w_wdata [NWR];
  logic [NWR-1:0]   w_wvalid;
  logic [ASIZE-1:0] w_raddr [NRD];
  logic [NREG-1:0]  w_clr;
  logic [NREG-1:0]  w_busy_eff;

  // A write port is effective only in range and, with the zero register, off address 0.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      w_waddr[p]  = waddr[p*ASIZE +: ASIZE];
      w_wdata[p]  = wdata[p*DSIZE +: DSIZE];
      w_wvalid[p] = wen[p] & ({1'b0, w_waddr[p]} < CW'(NREG))
                  & ~(ZERO_REG_EN && (w_waddr[p] == '0));
    end
    for (int r = 0; r < NRD; r++) begin
      w_raddr[r] = raddr[r*ASIZE +: ASIZE];
    end
    w_clr = '0;
    for (int i = 0; i < NREG; i++) begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wvalid[p] && (w_waddr[p] == ASIZE'(i))) w_clr[i] = 1'b1;
      end
    end
  end

  // NOTE: the storage array is reset because the architecture defines every
  // register as zero after reset; a reset-less RAM would not honour that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      // Ports are visited in ascending order so the highest port's write lands last.
      for (int p = 0; p < NWR; p++) begin
        for (int i = 0; i < NREG; i++) begin
          if (w_wvalid[p] && (w_waddr[p] == ASIZE'(i))) r_mem[i] <= w_wdata[p];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int r = 0; r < NRD; r++) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_raddr[r] == ASIZE'(i)) begin
          rdata[r*DSIZE +: DSIZE] = r_mem[i];
          rbusy[r]                = w_busy_eff[i];
        end
      end
      for (int p = 0; p < NWR; p++) begin
        if (w_wvalid[p] && (w_waddr[p] == w_raddr[r])) rdata[r*DSIZE +: DSIZE] = w_wdata[p];
      end
    end
  end

  regfile_scoreboard #(
    .ASIZE (ASIZE),
    .NREG  (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_eff (w_busy_eff),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default parameters).
// Expectations adapt when REGFILE_ZERO_REG_EN is defined.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  wen;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic [1:0]  rbusy;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        rsv_ok;
  logic [15:0] busy_vec;
  logic [BCNT_W-1:0] busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [3:0]  ra0, ra1;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [15:0] ex_rd0, ex_rd1;
    logic [1:0]  ex_rbusy;
    logic        ex_ok;
    logic [15:0] ex_vec;
    logic [4:0]  ex_cnt;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] w, input logic [3:0] a0, input logic [3:0] a1,
    input logic [15:0] d0, input logic [15:0] d1,
    input logic [3:0] r0, input logic [3:0] r1,
    input logic re, input logic [3:0] ra,
    input logic [15:0] e0, input logic [15:0] e1, input logic [1:0] eb,
    input logic eok, input logic [15:0] ev, input logic [4:0] ec);
    vec_t v;
    v.wen = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.ra0 = r0; v.ra1 = r1; v.rsv_en = re; v.rsv_addr = ra;
    v.ex_rd0 = e0; v.ex_rd1 = e1; v.ex_rbusy = eb; v.ex_ok = eok;
    v.ex_vec = ev; v.ex_cnt = ec;
    return v;
  endfunction

  task automatic idle_inputs();
    wen = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    //           wen   wa0 wa1 wd0       wd1       ra0 ra1 rsv  rsva  rd0                     rd1       rbusy         ok            vec                      cnt
    vt[0]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    0,  15, 0,   0,    16'h0,                  16'h0,    2'b00,        0,            16'h0000,                0);
    vt[1]  = mk(2'b11, 5,  5,  16'h1111, 16'h2222, 5,  6,  0,   0,    16'h2222,               16'h0,    2'b00,        0,            16'h0000,                0);
    vt[2]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    5,  6,  1,   3,    16'h2222,               16'h0,    2'b00,        1,            16'h0008,                1);
    vt[3]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    3,  5,  0,   0,    16'h0,                  16'h2222, 2'b01,        0,            16'h0008,                1);
    vt[4]  = mk(2'b01, 3,  0,  16'h00AB, 16'h0,    3,  5,  0,   0,    16'h00AB,               16'h2222, 2'b00,        0,            16'h0000,                0);
    vt[5]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    3,  5,  1,   7,    16'h00AB,               16'h2222, 2'b00,        1,            16'h0080,                1);
    vt[6]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    7,  5,  1,   7,    16'h0,                  16'h2222, 2'b01,        0,            16'h0080,                1);
    vt[7]  = mk(2'b10, 0,  7,  16'h0,    16'h7777, 7,  5,  1,   7,    16'h7777,               16'h2222, 2'b00,        1,            16'h0080,                1);
    vt[8]  = mk(2'b00, 0,  0,  16'h0,    16'h0,    7,  15, 1,   15,   16'h7777,               16'h0,    2'b01,        1,            16'h8080,                2);
    vt[9]  = mk(2'b01, 0,  0,  16'h5,    16'h0,    0,  15, 1,   0,    ZR ? 16'h0 : 16'h5,     16'h0,    2'b10,        !ZR,          ZR ? 16'h8080 : 16'h8081, ZR ? 5'd2 : 5'd3);
    vt[10] = mk(2'b10, 0,  15, 16'h0,    16'hF00D, 0,  15, 0,   0,    ZR ? 16'h0 : 16'h5,     16'hF00D, {1'b0, !ZR},  0,            ZR ? 16'h0080 : 16'h0081, ZR ? 5'd1 : 5'd2);
    vt[11] = mk(2'b11, 1,  2,  16'h00A1, 16'h00B2, 1,  2,  0,   0,    16'h00A1,               16'h00B2, 2'b00,        0,            ZR ? 16'h0080 : 16'h0081, ZR ? 5'd1 : 5'd2);
    vt[12] = mk(2'b01, 7,  0,  16'h0777, 16'h0,    1,  2,  0,   0,    16'h00A1,               16'h00B2, 2'b00,        0,            ZR ? 16'h0000 : 16'h0001, ZR ? 5'd0 : 5'd1);
    vt[13] = mk(2'b01, 0,  0,  16'h0,    16'h0,    0,  7,  0,   0,    16'h0,                  16'h0777, 2'b00,        0,            16'h0000,                0);

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy_vec", 32'(busy_vec), 32'h0);
    check("reset busy_cnt", 32'(busy_cnt), 32'h0);
    check("reset rbusy",    32'(rbusy),    32'h0);
    check("reset rsv_ok",   32'(rsv_ok),   32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 16; a++) begin
      raddr = {4'd0, 4'(a)};
      #1;
      check($sformatf("post-reset rdata r%0d", a), 32'(rdata[15:0]), 32'h0);
    end

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wen      = vt[i].wen;
      waddr    = {vt[i].wa1, vt[i].wa0};
      wdata    = {vt[i].wd1, vt[i].wd0};
      raddr    = {vt[i].ra1, vt[i].ra0};
      rsv_en   = vt[i].rsv_en;
      rsv_addr = vt[i].rsv_addr;
      #1;
      check($sformatf("v%0d rdata0", i), 32'(rdata[15:0]),  32'(vt[i].ex_rd0));
      check($sformatf("v%0d rdata1", i), 32'(rdata[31:16]), 32'(vt[i].ex_rd1));
      check($sformatf("v%0d rbusy", i),  32'(rbusy),        32'(vt[i].ex_rbusy));
      check($sformatf("v%0d rsv_ok", i), 32'(rsv_ok),       32'(vt[i].ex_ok));
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vt[i].ex_vec));
      check($sformatf("v%0d busy_cnt", i), 32'(busy_cnt), 32'(vt[i].ex_cnt));
    end

    // Asynchronous reset between edges drops all reservations at once.
    @(negedge clk);
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 4'd2;
    @(negedge clk);
    rsv_addr = 4'd9;
    @(negedge clk);
    idle_inputs();
    raddr = {4'd2, 4'd5};
    check("pre-async busy_vec", 32'(busy_vec), 32'h0204);
    check("pre-async busy_cnt", 32'(busy_cnt), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("async busy_vec", 32'(busy_vec),      32'h0);
    check("async busy_cnt", 32'(busy_cnt),      32'h0);
    check("async rdata r5", 32'(rdata[15:0]),   32'h0);
    check("async rbusy",    32'(rbusy),         32'h0);
    @(negedge clk);
    rst = 1'b1;
    raddr = {4'd1, 4'd7};
    #1;
    check("post-async rdata r7", 32'(rdata[15:0]),  32'h0);
    check("post-async rdata r1", 32'(rdata[31:16]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
